// File: rtl/mandel_coord_gen_if.sv
// Sample stream from the coordinate generator to the Mandelbrot calculator.
// Latency: none (wires only). Backpressure: out_ready from the slave stalls the master.
// Ports: out_valid/out_ready handshake, real_part/imaginary_part (Q4.28), pixel_x/pixel_y, last.
`timescale 1ns/1ps
interface mandel_coord_gen_if #(
  parameter int XW = 5,
  parameter int YW = 5
);
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   real_part;
  logic [31:0]   imaginary_part;
  logic [XW-1:0] pixel_x;
  logic [YW-1:0] pixel_y;
  logic          last;

  modport master (
    output out_valid, real_part, imaginary_part, pixel_x, pixel_y, last,
    input  out_ready
  );

  modport slave (
    input  out_valid, real_part, imaginary_part, pixel_x, pixel_y, last,
    output out_ready
  );
endinterface

// File: rtl/mandel_coord_gen.sv
// Raster-scan source of complex samples c = real + j*imag (signed Q4.28), one per pixel.
// Latency: first sample valid 1 cycle after start; 1 sample/cycle while out_ready stays high.
// Backpressure: out_ready low holds every output stable; a valid sample is never retracted.
// Ports: clk, reset (async, active-low), start, busy, frame_done, out (sample stream, master).
// Optional macro COORD_LOAD_EN adds cfg_x_start/cfg_y_start/cfg_step, captured on start in IDLE.
`timescale 1ns/1ps
module mandel_coord_gen #(
  parameter int          H_ACTIVE = 32,
  parameter int          V_ACTIVE = 24,
  parameter logic [31:0] X_START  = 32'hE000_0000,
  parameter logic [31:0] Y_START  = 32'h1200_0000,
  parameter logic [31:0] X_STEP   = 32'h0180_0000,
  parameter logic [31:0] Y_STEP   = 32'h0180_0000,
  localparam int         XW       = $clog2(H_ACTIVE),
  localparam int         YW       = $clog2(V_ACTIVE)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
`ifdef COORD_LOAD_EN
  input  logic [31:0]        cfg_x_start,
  input  logic [31:0]        cfg_y_start,
  input  logic [31:0]        cfg_step,
`endif
  output logic               busy,
  output logic               frame_done,
  mandel_coord_gen_if.master out
);

  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [31:0]   re_acc;
  logic [31:0]   im_acc;
  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;

  // Origin loaded on start, origin used at each row wrap, and the two steps.
  logic [31:0]   load_x;
  logic [31:0]   load_y;
  logic [31:0]   x_org;
  logic [31:0]   step_x;
  logic [31:0]   step_y;

  logic          xfer;
  logic          x_end;
  logic          y_end;
  logic          launch;

  assign launch = (state == IDLE) && start;
  assign xfer   = out.out_valid && out.out_ready;
  assign x_end  = (x_cnt == X_LAST);
  assign y_end  = (y_cnt == Y_LAST);

`ifdef COORD_LOAD_EN
  // The frame's origin/step are frozen at start so the cfg inputs may change mid-frame.
  logic [31:0] x_org_q;
  logic [31:0] step_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_org_q <= '0;
      step_q  <= '0;
    end else if (launch) begin
      x_org_q <= cfg_x_start;
      step_q  <= cfg_step;
    end
  end

  assign load_x = cfg_x_start;
  assign load_y = cfg_y_start;
  assign x_org  = x_org_q;
  assign step_x = step_q;
  assign step_y = step_q;
`else
  assign load_x = X_START;
  assign load_y = Y_START;
  assign x_org  = X_START;
  assign step_x = X_STEP;
  assign step_y = Y_STEP;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; start is only looked at in IDLE, so it never queues.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (xfer && x_end && y_end) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Coordinate accumulators: add/sub only, 32-bit wrap on overflow.
  // After the final transfer the counters simply hold; DONE ends the frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      re_acc <= '0;
      im_acc <= '0;
      x_cnt  <= '0;
      y_cnt  <= '0;
    end else if (launch) begin
      re_acc <= load_x;
      im_acc <= load_y;
      x_cnt  <= '0;
      y_cnt  <= '0;
    end else if (xfer) begin
      if (!x_end) begin
        x_cnt  <= x_cnt + XW'(1);
        re_acc <= re_acc + step_x;
      end else if (!y_end) begin
        x_cnt  <= '0;
        re_acc <= x_org;
        y_cnt  <= y_cnt + YW'(1);
        im_acc <= im_acc - step_y;
      end
    end
  end

  assign out.out_valid      = (state == RUN);
  assign out.real_part      = re_acc;
  assign out.imaginary_part = im_acc;
  assign out.pixel_x        = x_cnt;
  assign out.pixel_y        = y_cnt;
  assign out.last           = x_end && y_end && out.out_valid;
  assign busy               = (state == RUN);
  assign frame_done         = (state == DONE);

endmodule

// File: tb/tb_mandel_coord_gen.sv
// Self-checking bench for mandel_coord_gen against a raster/arithmetic reference model.
// Latency: n/a. Backpressure: out_ready driven constant-high or pseudo-randomly.
// Build with +define+COORD_LOAD_EN to include the zoom/pan configuration scenario.
`timescale 1ns/1ps
module tb_mandel_coord_gen;

  localparam int H  = 32;
  localparam int V  = 24;
  localparam int N  = H * V;
  localparam int XW = $clog2(H);
  localparam int YW = $clog2(V);

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic frame_done;
`ifdef COORD_LOAD_EN
  logic [31:0] cfg_x_start = '0;
  logic [31:0] cfg_y_start = '0;
  logic [31:0] cfg_step    = '0;
`endif

  mandel_coord_gen_if #(.XW(XW), .YW(YW)) bus();

  mandel_coord_gen #(
    .H_ACTIVE (H),
    .V_ACTIVE (V)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
`ifdef COORD_LOAD_EN
    .cfg_x_start (cfg_x_start),
    .cfg_y_start (cfg_y_start),
    .cfg_step    (cfg_step),
`endif
    .busy        (busy),
    .frame_done  (frame_done),
    .out         (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model parameters: sample k sits at column k%H, row k/H.
  logic [31:0] m_x0 = 32'hE000_0000;
  logic [31:0] m_y0 = 32'h1200_0000;
  logic [31:0] m_sx = 32'h0180_0000;
  logic [31:0] m_sy = 32'h0180_0000;

  logic [31:0] cap_real [N];
  logic [31:0] cap_imag [N];

  function automatic logic [31:0] ref_real(input int idx);
    logic [31:0] col;
    col = 32'(idx % H);
    return m_x0 + col * m_sx;
  endfunction

  function automatic logic [31:0] ref_imag(input int idx);
    logic [31:0] row;
    row = 32'(idx / H);
    return m_y0 - row * m_sy;
  endfunction

  // Runs from the negedge where the first sample should be visible until the
  // IDLE cycle after frame_done, checking every visible sample against the model.
  task automatic drive_frame(input string tag, input bit rand_ready, input bit poke_start,
                             input bit keep_start, output int transfers, output int done_cnt);
    int idx = 0;
    int cyc = 0;
    bit rdy;
    done_cnt = 0;
    while (idx < N && cyc < 4 * N) begin
      n_checks++;
      if (bus.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL %s valid idx=%0d got=%b exp=1", tag, idx, bus.out_valid);
      end else begin
        n_checks++;
        if (bus.pixel_x !== XW'(idx % H) || bus.pixel_y !== YW'(idx / H)) begin
          n_fail++;
          $display("FAIL %s pixel idx=%0d got=(%0d,%0d) exp=(%0d,%0d)", tag, idx,
                   bus.pixel_x, bus.pixel_y, idx % H, idx / H);
        end
        n_checks++;
        if (bus.real_part !== ref_real(idx) || bus.imaginary_part !== ref_imag(idx)) begin
          n_fail++;
          $display("FAIL %s coord idx=%0d got=%h/%h exp=%h/%h", tag, idx,
                   bus.real_part, bus.imaginary_part, ref_real(idx), ref_imag(idx));
        end
        n_checks++;
        if (bus.last !== (idx == N - 1)) begin
          n_fail++;
          $display("FAIL %s last idx=%0d got=%b exp=%b", tag, idx, bus.last, idx == N - 1);
        end
      end
      n_checks++;
      if (frame_done !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s run_flags idx=%0d got done=%b busy=%b exp done=0 busy=1",
                 tag, idx, frame_done, busy);
      end
      rdy = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.out_ready = rdy;
      start = keep_start ? 1'b1 : (poke_start ? 1'($urandom_range(0, 1)) : 1'b0);
      if (rdy && bus.out_valid === 1'b1) begin
        cap_real[idx] = bus.real_part;
        cap_imag[idx] = bus.imaginary_part;
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    transfers = idx;
    if (idx < N) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout transfers got=%0d exp=%0d", tag, idx, N);
    end
    if (!keep_start) start = 1'b0;
    // DONE cycle
    n_checks++;
    if (frame_done !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_cycle got done=%b valid=%b busy=%b exp 1/0/0",
               tag, frame_done, bus.out_valid, busy);
    end
    if (frame_done === 1'b1) done_cnt++;
    @(negedge clk);
    // IDLE cycle
    n_checks++;
    if (frame_done !== 1'b0 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_cycle got done=%b valid=%b busy=%b exp 0/0/0",
               tag, frame_done, bus.out_valid, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    n_checks++;
    if ({bus.out_valid, bus.last, busy, frame_done} !== 4'b0 || bus.real_part !== 32'h0 ||
        bus.imaginary_part !== 32'h0 || bus.pixel_x !== '0 || bus.pixel_y !== '0) begin
      n_fail++;
      $display("FAIL reset_values got valid=%b last=%b busy=%b done=%b re=%h im=%h x=%0d y=%0d exp all 0",
               bus.out_valid, bus.last, busy, frame_done, bus.real_part, bus.imaginary_part,
               bus.pixel_x, bus.pixel_y);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_start got valid=%b busy=%b exp 0/0", bus.out_valid, busy);
    end
  endtask

  task automatic test_first_sample();
    bus.out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.pixel_x !== '0 || bus.pixel_y !== '0 ||
        bus.real_part !== 32'hE000_0000 || bus.imaginary_part !== 32'h1200_0000) begin
      n_fail++;
      $display("FAIL first_sample got v=%b (%0d,%0d) %h/%h exp v=1 (0,0) e0000000/12000000",
               bus.out_valid, bus.pixel_x, bus.pixel_y, bus.real_part, bus.imaginary_part);
    end
    @(negedge clk);
    n_checks++;
    if (bus.pixel_x !== XW'(1) || bus.real_part !== 32'hE180_0000) begin
      n_fail++;
      $display("FAIL second_sample got x=%0d re=%h exp x=1 re=e1800000", bus.pixel_x, bus.real_part);
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_frame();
    int tr, dn;
    bus.out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    drive_frame("full", 1'b0, 1'b0, 1'b0, tr, dn);
    n_checks++;
    if (tr != N || dn != 1) begin
      n_fail++;
      $display("FAIL full_count got transfers=%0d done=%0d exp %0d/1", tr, dn, N);
    end
    n_checks++;
    if (cap_real[H] !== 32'hE000_0000 || cap_imag[H] !== 32'h1080_0000) begin
      n_fail++;
      $display("FAIL full_row1 got %h/%h exp e0000000/10800000", cap_real[H], cap_imag[H]);
    end
    n_checks++;
    if (cap_real[N-1] !== 32'h0E80_0000 || cap_imag[N-1] !== 32'hEF80_0000) begin
      n_fail++;
      $display("FAIL full_last got %h/%h exp 0e800000/ef800000", cap_real[N-1], cap_imag[N-1]);
    end
  endtask

  task automatic test_backpressure();
    int tr, dn;
    bus.out_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    drive_frame("bp", 1'b1, 1'b0, 1'b0, tr, dn);
    n_checks++;
    if (tr != N || dn != 1) begin
      n_fail++;
      $display("FAIL bp_count got transfers=%0d done=%0d exp %0d/1", tr, dn, N);
    end
  endtask

  task automatic test_start_ignored();
    int tr, dn;
    start = 1'b1;
    @(negedge clk);
    drive_frame("poke", 1'b1, 1'b1, 1'b0, tr, dn);
    n_checks++;
    if (tr != N || dn != 1) begin
      n_fail++;
      $display("FAIL poke_count got transfers=%0d done=%0d exp %0d/1", tr, dn, N);
    end
  endtask

  task automatic test_back_to_back();
    int tr, dn;
    start = 1'b1;
    @(negedge clk);
    drive_frame("hold1", 1'b0, 1'b0, 1'b1, tr, dn);
    // start still high: sampled in the IDLE cycle, so the next frame is already running here
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL retrigger got busy=%b exp 1", busy);
    end
    drive_frame("hold2", 1'b1, 1'b0, 1'b0, tr, dn);
    n_checks++;
    if (tr != N || dn != 1) begin
      n_fail++;
      $display("FAIL hold2_count got transfers=%0d done=%0d exp %0d/1", tr, dn, N);
    end
  endtask

  task automatic test_reset_abort();
    int tr, dn;
    int cyc = 0;
    bus.out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!(bus.pixel_x == XW'(10) && bus.pixel_y == YW'(5)) && cyc < 2 * N) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (bus.pixel_x !== XW'(10) || bus.pixel_y !== YW'(5) || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_reach got (%0d,%0d) v=%b exp (10,5) v=1", bus.pixel_x, bus.pixel_y, bus.out_valid);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({bus.out_valid, bus.last, busy, frame_done} !== 4'b0 || bus.real_part !== 32'h0 ||
        bus.imaginary_part !== 32'h0 || bus.pixel_x !== '0 || bus.pixel_y !== '0) begin
      n_fail++;
      $display("FAIL abort_reset got valid=%b busy=%b done=%b re=%h im=%h x=%0d y=%0d exp all 0",
               bus.out_valid, busy, frame_done, bus.real_part, bus.imaginary_part,
               bus.pixel_x, bus.pixel_y);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (frame_done !== 1'b0 || bus.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_quiet cyc=%0d got done=%b valid=%b exp 0/0", i, frame_done, bus.out_valid);
      end
    end
    start = 1'b1;
    @(negedge clk);
    drive_frame("restart", 1'b0, 1'b0, 1'b0, tr, dn);
    n_checks++;
    if (cap_real[0] !== 32'hE000_0000 || cap_imag[0] !== 32'h1200_0000 || tr != N || dn != 1) begin
      n_fail++;
      $display("FAIL restart got %h/%h tr=%0d dn=%0d exp e0000000/12000000 %0d/1",
               cap_real[0], cap_imag[0], tr, dn, N);
    end
  endtask

`ifdef COORD_LOAD_EN
  task automatic test_coord_load();
    int tr, dn;
    m_x0 = 32'hF000_0000;
    m_y0 = 32'h0800_0000;
    m_sx = 32'h0040_0000;
    m_sy = 32'h0040_0000;
    cfg_x_start = m_x0;
    cfg_y_start = m_y0;
    cfg_step    = m_sx;
    start = 1'b1;
    @(negedge clk);
    // Captured at start; later changes must not disturb this frame.
    cfg_x_start = $urandom;
    cfg_y_start = $urandom;
    cfg_step    = $urandom;
    drive_frame("cfg", 1'b1, 1'b0, 1'b0, tr, dn);
    n_checks++;
    if (cap_real[1] !== 32'hF040_0000 || cap_imag[H] !== 32'h07C0_0000 || tr != N) begin
      n_fail++;
      $display("FAIL cfg_samples got re(1,0)=%h im(0,1)=%h tr=%0d exp f0400000/07c00000/%0d",
               cap_real[1], cap_imag[H], tr, N);
    end
  endtask
`endif

  initial begin
    bus.out_ready = 1'b0;
    test_reset();
    test_first_sample();
    test_full_frame();
    test_backpressure();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
`ifdef COORD_LOAD_EN
    test_coord_load();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
